// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uiuart_tx byte transmitter among N_REQ byte sources. A
// round-robin arbiter picks the next source; a requester can keep the grant
// across several bytes by holding I_lock so that a multi-byte message goes out
// contiguously. The block drives the transmitter handshake itself: a one-cycle
// write request, then it follows I_uart_wbusy up and back down before the next
// byte is considered.
//
// Optional feature (compile-time macro UART_ARB_TIMEOUT_EN):
//   When defined, a byte whose write request is not answered by I_uart_wbusy
//   within TIMEOUT_CYC cycles is dropped, O_err pulses for one cycle and the
//   rotation moves on. The TIMEOUT_CYC parameter only exists in that build.
//   When undefined, the arbiter waits indefinitely and O_err is tied low.
//
// Parameters:
//   N_REQ        number of requesters (2..8)
//   TIMEOUT_CYC  cycles allowed for I_uart_wbusy to rise (timeout build only)
//
// Ports:
//   I_clk         system clock (shared with uiuart_tx)
//   I_rst         synchronous active-high reset
//   I_req         per-requester "byte pending" level
//   I_data        requester k byte on bits [8k+7:8k]
//   I_lock        keep the grant after the current byte
//   O_ack         one-cycle pulse, requester's byte accepted
//   O_grant       one-hot current/last owner, 0 when no owner
//   O_uart_wreq   one-cycle write request to uiuart_tx
//   O_uart_wdata  byte to uiuart_tx, stable from wreq until back in IDLE
//   I_uart_wbusy  uiuart_tx busy flag
//   O_busy        high whenever a byte is in progress
//   O_err         one-cycle timeout pulse
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ       = 4
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic [N_REQ-1:0]   I_req,
  input  logic [8*N_REQ-1:0] I_data,
  input  logic [N_REQ-1:0]   I_lock,
  output logic [N_REQ-1:0]   O_ack,
  output logic [N_REQ-1:0]   O_grant,
  output logic               O_uart_wreq,
  output logic [7:0]         O_uart_wdata,
  input  logic               I_uart_wbusy,
  output logic               O_busy,
  output logic               O_err
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  idx_t               rr_ptr_q, rr_ptr_d;
  idx_t               owner_q, owner_d;
  logic               locked_q, locked_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               wreq_q, wreq_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               busy_q, busy_d;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               err_q, err_d;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin search: first requester at or after rr_ptr_q, wrapping.
  // ---------------------------------------------------------------------------
  logic               rr_found;
  idx_t               rr_idx;
  logic [IDX_W:0]     rr_sum;
  idx_t               rr_cand;

  // NOTE: every variable written in an always_comb gets a value before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    rr_cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (rr_sum >= (IDX_W+1)'(N_REQ)) begin
        rr_sum = rr_sum - (IDX_W+1)'(N_REQ);
      end
      rr_cand = rr_sum[IDX_W-1:0];
      if (!rr_found && I_req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // Requester after the current owner, used when the rotation advances.
  idx_t owner_next;
  assign owner_next = (owner_q == idx_t'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  logic               win;
  idx_t               win_idx;
  logic [N_REQ-1:0]   win_onehot;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    locked_d   = locked_q;
    grant_d    = grant_q;
    wdata_d    = wdata_q;
    ack_d      = '0;
    wreq_d     = 1'b0;
    win        = 1'b0;
    win_idx    = owner_q;
    win_onehot = '0;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // A byte still shifting out of the transmitter (including one that
        // survived a reset of this block) holds off all arbitration.
        if (!I_uart_wbusy) begin
          if (locked_q) begin
            if (I_req[owner_q]) begin
              win     = 1'b1;
              win_idx = owner_q;
            end else if (!I_lock[owner_q]) begin
              // Owner abandoned its message: release and arbitrate normally.
              locked_d = 1'b0;
              win      = rr_found;
              win_idx  = rr_idx;
            end
          end else begin
            win     = rr_found;
            win_idx = rr_idx;
          end

          if (win) begin
            win_onehot[win_idx] = 1'b1;
            ack_d    = win_onehot;
            grant_d  = win_onehot;
            wreq_d   = 1'b1;
            wdata_d  = I_data[{win_idx, 3'b000} +: 8];
            owner_d  = win_idx;
            locked_d = I_lock[win_idx];
            state_d  = ST_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end
        end
      end

      ST_WAIT_BUSY: begin
        if (I_uart_wbusy) begin
          state_d = ST_WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Transmitter never answered: drop the byte and move on.
          err_d    = 1'b1;
          state_d  = ST_IDLE;
          rr_ptr_d = owner_next;
          locked_d = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      ST_WAIT_DONE: begin
        if (!I_uart_wbusy) begin
          state_d = ST_IDLE;
          // A locked owner keeps its place at the head of the rotation.
          if (!locked_q) begin
            rr_ptr_d = owner_next;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge I_clk) begin
    // NOTE: the reset is synchronous, so it sits inside the clocked branch
    // and is not in the sensitivity list.
    if (I_rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      ack_q    <= '0;
      grant_q  <= '0;
      wreq_q   <= 1'b0;
      wdata_q  <= 8'h00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      wreq_q   <= wreq_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign O_err = err_q;
`else
  assign O_err = 1'b0;
`endif

  assign O_ack        = ack_q;
  assign O_grant      = grant_q;
  assign O_uart_wreq  = wreq_q;
  assign O_uart_wdata = wdata_q;
  assign O_busy       = busy_q;

endmodule
